// File: rtl/hazard_ctrl.sv
// hazard_ctrl: operand forwarding selects, W->M store bypass, load-use
// interlock and a multi-cycle mult/div sequencer for the DX stage.
// Optional feature macro: HAZ_PERF_EN (performance counters stall_cycles / md_ops).
module hazard_ctrl #(
    parameter int unsigned STATUS_REG = 30,
    parameter int unsigned LINK_REG   = 31,
    parameter int unsigned MD_TIMEOUT = 64,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [31:0]      fd_ir,
    input  logic [31:0]      dx_ir,
    input  logic [31:0]      xm_ir,
    input  logic [31:0]      mw_ir,
    input  logic             xm_ovf,
    input  logic             mw_ovf,
    input  logic             md_ready,
    output logic [1:0]       muxA_sel,
    output logic [1:0]       muxB_sel,
    output logic             wm_sel,
    output logic             stall_fd,
    output logic             stall_dx,
    output logic             bubble_dx,
    output logic             bubble_xm,
    output logic             md_start,
    output logic             md_res_sel,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] md_ops
);

    localparam logic [4:0] OP_RTYPE = 5'b00000;
    localparam logic [4:0] OP_J     = 5'b00001;
    localparam logic [4:0] OP_BNE   = 5'b00010;
    localparam logic [4:0] OP_JAL   = 5'b00011;
    localparam logic [4:0] OP_JR    = 5'b00100;
    localparam logic [4:0] OP_BLT   = 5'b00110;
    localparam logic [4:0] OP_SW    = 5'b00111;
    localparam logic [4:0] OP_LW    = 5'b01000;
    localparam logic [4:0] OP_SETX  = 5'b10101;
    localparam logic [4:0] OP_BEX   = 5'b10110;
    localparam logic [4:0] ALU_MUL  = 5'b00110;
    localparam logic [4:0] ALU_DIV  = 5'b00111;

    localparam logic [4:0] STATUS_IDX   = 5'(STATUS_REG);
    localparam logic [4:0] LINK_IDX     = 5'(LINK_REG);
    localparam logic [7:0] TIMEOUT_LAST = 8'(MD_TIMEOUT - 1);

    localparam logic [1:0] SEL_XM = 2'b00;
    localparam logic [1:0] SEL_MW = 2'b01;
    localparam logic [1:0] SEL_RF = 2'b10;

    typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Register index written by an instruction; 0 means "writes nothing".
    function automatic logic [4:0] writer_idx(input logic [31:0] ir, input logic ovf);
        case (ir[31:27])
            OP_SW, OP_BNE, OP_BLT, OP_J, OP_JR, OP_BEX: writer_idx = 5'd0;
            OP_JAL:  writer_idx = LINK_IDX;
            OP_SETX: writer_idx = STATUS_IDX;
            default: writer_idx = ovf ? STATUS_IDX : ir[26:22];
        endcase
    endfunction

    // Second source operand as {valid, index}.
    function automatic logic [5:0] src_b(input logic [31:0] ir);
        case (ir[31:27])
            OP_RTYPE:                  src_b = {1'b1, ir[16:12]};
            OP_BEX:                    src_b = {1'b1, STATUS_IDX};
            OP_SW, OP_BNE, OP_BLT, OP_JR: src_b = {1'b1, ir[26:22]};
            default:                   src_b = {1'b0, 5'd0};
        endcase
    endfunction

    // Operand source: youngest matching writer wins, index 0 never forwards.
    function automatic logic [1:0] fwd_sel(input logic vld, input logic [4:0] src,
                                           input logic [4:0] xm_w, input logic [4:0] mw_w);
        if (!vld)                             fwd_sel = SEL_RF;
        else if (xm_w != 5'd0 && src == xm_w) fwd_sel = SEL_XM;
        else if (mw_w != 5'd0 && src == mw_w) fwd_sel = SEL_MW;
        else                                  fwd_sel = SEL_RF;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        tmo_q, tmo_d;

    logic [4:0]  xm_w_s, mw_w_s;
    logic [5:0]  dx_b_s, fd_b_s;
    logic        dx_is_md_s, load_use_s, md_stall_s, release_s, tmo_hit_s;

    // Stage decode: writer indices, source operands, hazard conditions.
    always_comb begin
        xm_w_s     = writer_idx(xm_ir, xm_ovf);
        mw_w_s     = writer_idx(mw_ir, mw_ovf);
        dx_b_s     = src_b(dx_ir);
        fd_b_s     = src_b(fd_ir);
        dx_is_md_s = (dx_ir[31:27] == OP_RTYPE) &&
                     (dx_ir[6:2] == ALU_MUL || dx_ir[6:2] == ALU_DIV);
        load_use_s = (dx_ir[31:27] == OP_LW) && (dx_ir[26:22] != 5'd0) &&
                     ((fd_ir[21:17] == dx_ir[26:22]) ||
                      (fd_b_s[5] && fd_b_s[4:0] == dx_ir[26:22]));
        release_s  = (state_q == RUN) && (md_ready || cnt_q == TIMEOUT_LAST);
        tmo_hit_s  = (state_q == RUN) && !md_ready && (cnt_q == TIMEOUT_LAST);
    end

    // Sequencer state, timeout count and sticky timeout flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    // Sequencer next state: start on a mul/div in DX, leave on ready or timeout.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        case (state_q)
            IDLE: begin
                if (dx_is_md_s) begin
                    state_d = RUN;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (release_s) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (tmo_hit_s) begin
                    tmo_d = 1'b1;
                end else begin
                    tmo_d = tmo_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pipeline control outputs; everything is quiet while reset is held.
    always_comb begin
        md_start   = 1'b0;
        md_res_sel = 1'b0;
        md_stall_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (dx_is_md_s) begin
                    md_start   = 1'b1;
                    md_stall_s = 1'b1;
                end else begin
                    md_stall_s = 1'b0;
                end
            end
            RUN: begin
                if (release_s) begin
                    md_res_sel = 1'b1;
                end else begin
                    md_stall_s = 1'b1;
                end
            end
            default: md_stall_s = 1'b0;
        endcase
        muxA_sel  = fwd_sel(1'b1, dx_ir[21:17], xm_w_s, mw_w_s);
        muxB_sel  = fwd_sel(dx_b_s[5], dx_b_s[4:0], xm_w_s, mw_w_s);
        wm_sel    = (xm_ir[31:27] == OP_SW) && (mw_w_s != 5'd0) && (xm_ir[26:22] == mw_w_s);
        stall_fd  = md_stall_s | load_use_s;
        stall_dx  = md_stall_s;
        bubble_dx = load_use_s;
        bubble_xm = md_stall_s;
        if (reset) begin
            md_start   = 1'b0;
            md_res_sel = 1'b0;
            muxA_sel   = SEL_RF;
            muxB_sel   = SEL_RF;
            wm_sel     = 1'b0;
            stall_fd   = 1'b0;
            stall_dx   = 1'b0;
            bubble_dx  = 1'b0;
            bubble_xm  = 1'b0;
        end else begin
            md_stall_s = md_stall_s;
        end
    end

    assign md_timeout = tmo_q;

`ifdef HAZ_PERF_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] md_ops_q, md_ops_d;

    // Counter increments; both wrap naturally.
    always_comb begin
        stall_cycles_d = stall_cycles_q + (stall_fd ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}});
        md_ops_d       = md_ops_q + (md_start ? {{(CNT_W-1){1'b0}}, 1'b1} : {CNT_W{1'b0}});
    end

    // Performance counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles_q <= {CNT_W{1'b0}};
            md_ops_q       <= {CNT_W{1'b0}};
        end else begin
            stall_cycles_q <= stall_cycles_d;
            md_ops_q       <= md_ops_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign md_ops       = md_ops_q;
`else
    assign stall_cycles = {CNT_W{1'b0}};
    assign md_ops       = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl (built with MD_TIMEOUT = 8).
module tb_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] fd_ir, dx_ir, xm_ir, mw_ir;
    logic        xm_ovf, mw_ovf, md_ready;
    logic [1:0]  muxA_sel, muxB_sel;
    logic        wm_sel, stall_fd, stall_dx, bubble_dx, bubble_xm;
    logic        md_start, md_res_sel, md_timeout;
    logic [31:0] stall_cycles, md_ops;

    int errors = 0;
    int checks = 0;

    hazard_ctrl #(.STATUS_REG(30), .LINK_REG(31), .MD_TIMEOUT(8), .CNT_W(32)) dut (
        .clock(clock), .reset(reset),
        .fd_ir(fd_ir), .dx_ir(dx_ir), .xm_ir(xm_ir), .mw_ir(mw_ir),
        .xm_ovf(xm_ovf), .mw_ovf(mw_ovf), .md_ready(md_ready),
        .muxA_sel(muxA_sel), .muxB_sel(muxB_sel), .wm_sel(wm_sel),
        .stall_fd(stall_fd), .stall_dx(stall_dx), .bubble_dx(bubble_dx), .bubble_xm(bubble_xm),
        .md_start(md_start), .md_res_sel(md_res_sel), .md_timeout(md_timeout),
        .stall_cycles(stall_cycles), .md_ops(md_ops)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] fd, dx, xm, mw;
        logic        xo, mo;
        logic [1:0]  a, b;
        logic        wm, sf, bd;
    } vec_t;

    vec_t vecs[13];

    function automatic logic [31:0] rt(input logic [4:0] rd, input logic [4:0] rs,
                                       input logic [4:0] rtt, input logic [4:0] alu);
        return {5'b00000, rd, rs, rtt, 5'b00000, alu, 2'b00};
    endfunction

    function automatic logic [31:0] it(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rs);
        return {op, rd, rs, 17'd0};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setv(input string n, input logic [31:0] f, input logic [31:0] d,
                        input logic [31:0] x, input logic [31:0] m, input logic xo, input logic mo,
                        input logic [1:0] a, input logic [1:0] b, input logic wm,
                        input logic sf, input logic bd, input int idx);
        vecs[idx] = '{n, f, d, x, m, xo, mo, a, b, wm, sf, bd};
    endtask

    // Runs one mul/div from its start cycle until release (or a 20-cycle bound).
    // ready_at: loop index (0 = start cycle) at which md_ready is raised; -1 = never.
    task automatic run_md(input int ready_at, output int starts, output int stalls,
                          output int res, output int rel_k);
        bit released = 1'b0;
        starts = 0; stalls = 0; res = 0; rel_k = -1;
        dx_ir = rt(5'd1, 5'd2, 5'd3, 5'b00110);
        for (int k = 0; k < 20; k++) begin
            md_ready = (ready_at >= 0 && k == ready_at);
            @(negedge clock);
            starts += int'(md_start);
            stalls += int'(stall_fd);
            if (md_res_sel) begin
                res++;
                rel_k = k;
                released = 1'b1;
            end
            @(posedge clock); #1;
            if (released) begin
                dx_ir = 32'd0;
                md_ready = 1'b0;
                break;
            end
        end
        dx_ir = 32'd0;
        md_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    int st, sl, rs_n, rk;

    initial begin
        logic [31:0] mul_ir;
        mul_ir = rt(5'd1, 5'd2, 5'd3, 5'b00110);
        setv("xm_mw_r5",      32'd0, rt(5'd1,5'd5,5'd5,5'd0), it(5'b00101,5'd5,5'd0), rt(5'd5,5'd1,5'd2,5'd0), 0,0, 2'b00,2'b00,0,0,0, 0);
        setv("mw_only_r5",    32'd0, rt(5'd1,5'd5,5'd5,5'd0), 32'd0,                  rt(5'd5,5'd1,5'd2,5'd0), 0,0, 2'b01,2'b01,0,0,0, 1);
        setv("xm_ovf_bex",    32'd0, it(5'b10110,5'd0,5'd0),  rt(5'd7,5'd1,5'd2,5'd0), 32'd0,                 1,0, 2'b10,2'b00,0,0,0, 2);
        setv("jal_jr31",      32'd0, it(5'b00100,5'd31,5'd0), it(5'b00011,5'd0,5'd0), 32'd0,                  0,0, 2'b10,2'b00,0,0,0, 3);
        setv("writer_r0",     32'd0, rt(5'd1,5'd0,5'd0,5'd0), rt(5'd0,5'd1,5'd2,5'd0), rt(5'd0,5'd3,5'd4,5'd0), 0,0, 2'b10,2'b10,0,0,0, 4);
        setv("load_use",      rt(5'd4,5'd3,5'd2,5'd0), it(5'b01000,5'd3,5'd0), 32'd0, 32'd0,                  0,0, 2'b10,2'b10,0,1,1, 5);
        setv("wm_r9",         32'd0, 32'd0, it(5'b00111,5'd9,5'd1), rt(5'd9,5'd1,5'd2,5'd0),                   0,0, 2'b10,2'b10,1,0,0, 6);
        setv("wm_r9_vs_r8",   32'd0, 32'd0, it(5'b00111,5'd9,5'd1), rt(5'd8,5'd1,5'd2,5'd0),                   0,0, 2'b10,2'b10,0,0,0, 7);
        setv("mw_ovf_r30",    32'd0, rt(5'd1,5'd30,5'd2,5'd0), 32'd0, rt(5'd7,5'd1,5'd2,5'd0),                 0,1, 2'b01,2'b10,0,0,0, 8);
        setv("b_only_r5",     32'd0, rt(5'd1,5'd6,5'd5,5'd0), it(5'b00101,5'd5,5'd0), rt(5'd5,5'd1,5'd2,5'd0), 0,0, 2'b10,2'b00,0,0,0, 9);
        setv("load_use_swrd", it(5'b00111,5'd3,5'd1), it(5'b01000,5'd3,5'd0), 32'd0, 32'd0,                   0,0, 2'b10,2'b10,0,1,1, 10);
        setv("lw_r0",         rt(5'd4,5'd0,5'd0,5'd0), it(5'b01000,5'd0,5'd0), 32'd0, 32'd0,                   0,0, 2'b10,2'b10,0,0,0, 11);
        setv("sw_not_writer", 32'd0, rt(5'd1,5'd5,5'd5,5'd0), it(5'b00111,5'd5,5'd1), 32'd0,                   0,0, 2'b10,2'b10,0,0,0, 12);

        // Reset state with hazards present on every input.
        reset = 1'b1; md_ready = 1'b0; xm_ovf = 1'b0; mw_ovf = 1'b0;
        fd_ir = rt(5'd4,5'd1,5'd2,5'd0); dx_ir = mul_ir;
        xm_ir = rt(5'd2,5'd0,5'd0,5'd0); mw_ir = rt(5'd3,5'd0,5'd0,5'd0);
        @(posedge clock); @(posedge clock); #1;
        @(negedge clock);
        chk("reset_ctrl", {stall_fd, stall_dx, bubble_dx, bubble_xm, md_start, md_res_sel, md_timeout, wm_sel}, 64'h0);
        chk("reset_sel", {muxA_sel, muxB_sel}, 64'b1010);
        chk("reset_cnt", {stall_cycles, md_ops}, 64'h0);
        @(posedge clock); #1;
        dx_ir = 32'd0; fd_ir = 32'd0; xm_ir = 32'd0; mw_ir = 32'd0;
        reset = 1'b0;

        // Combinational vector table.
        for (int i = 0; i < 13; i++) begin
            fd_ir = vecs[i].fd; dx_ir = vecs[i].dx; xm_ir = vecs[i].xm; mw_ir = vecs[i].mw;
            xm_ovf = vecs[i].xo; mw_ovf = vecs[i].mo;
            @(negedge clock);
            chk(vecs[i].name, {muxA_sel, muxB_sel, wm_sel, stall_fd, bubble_dx},
                {vecs[i].a, vecs[i].b, vecs[i].wm, vecs[i].sf, vecs[i].bd});
            @(posedge clock); #1;
        end
        xm_ovf = 1'b0; mw_ovf = 1'b0; fd_ir = 32'd0; xm_ir = 32'd0; mw_ir = 32'd0;

        // Load-use lasts one cycle: after the bubble the lw has moved on.
        fd_ir = rt(5'd4,5'd3,5'd2,5'd0); dx_ir = it(5'b01000,5'd3,5'd0);
        @(negedge clock);
        chk("lu_cycle1", {stall_fd, bubble_dx, stall_dx}, 64'b110);
        @(posedge clock); #1;
        dx_ir = 32'd0; xm_ir = it(5'b01000,5'd3,5'd0);
        @(negedge clock);
        chk("lu_cycle2", {stall_fd, bubble_dx}, 64'b00);
        @(posedge clock); #1;
        fd_ir = 32'd0; xm_ir = 32'd0;

        // Mult/div with ready after 5 RUN cycles.
        do_reset();
        @(negedge clock);
        chk("md_start_cycle", {md_start, stall_fd, stall_dx, bubble_xm}, 64'b0000);
        @(posedge clock); #1;
        dx_ir = mul_ir;
        @(negedge clock);
        chk("md_start_pulse", {md_start, stall_fd, stall_dx, bubble_xm, md_res_sel}, 64'b11110);
        @(posedge clock); #1;
        begin
            int s2, l2, r2, k2;
            run_md(5, s2, l2, r2, k2);
            st = 1 + s2; sl = 1 + l2; rs_n = r2; rk = k2 + 1;
        end
        chk("md_starts", st, 1);
        chk("md_stall_cycles", sl, 6);
        chk("md_res_sel_count", rs_n, 1);
        chk("md_release_cycle", rk, 6);
        @(negedge clock);
        chk("md_idle_after", {md_start, stall_fd, md_res_sel, md_timeout}, 64'b0000);
`ifdef HAZ_PERF_EN
        chk("perf_md_ops", md_ops, 1);
        chk("perf_stall_cycles", stall_cycles, 6);
`else
        chk("perf_off", {stall_cycles, md_ops}, 64'h0);
`endif
        @(posedge clock); #1;

        // Timeout: md_ready never arrives, MD_TIMEOUT = 8.
        do_reset();
        run_md(-1, st, sl, rs_n, rk);
        chk("tmo_release_cycle", rk, 8);
        chk("tmo_stall_cycles", sl, 8);
        chk("tmo_starts", st, 1);
        @(negedge clock);
        chk("tmo_flag", {md_timeout, stall_fd}, 64'b10);
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("tmo_sticky", md_timeout, 1);
        @(posedge clock); #1;
        do_reset();
        @(negedge clock);
        chk("tmo_cleared", md_timeout, 0);
        @(posedge clock); #1;

        // Reset while in RUN returns to IDLE without a result select.
        dx_ir = mul_ir;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("run_before_reset", {stall_fd, md_start}, 64'b10);
        @(posedge clock); #1;
        reset = 1'b1; md_ready = 1'b1;
        @(negedge clock);
        chk("run_in_reset", {md_res_sel, stall_fd, md_start}, 64'b000);
        @(posedge clock); #1;
        reset = 1'b0; dx_ir = 32'd0;
        @(negedge clock);
        chk("run_after_reset", {md_res_sel, stall_fd, md_start}, 64'b000);
        md_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
